// File: rtl/cpu_defs.sv
// Shared definitions for CPU IO-bus peripherals: interrupt controller state
// encodings and register offsets.
package cpu_defs;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

  localparam logic [1:0] IC_ENABLE  = 2'd0;
  localparam logic [1:0] IC_PENDING = 2'd1;
  localparam logic [1:0] IC_STATUS  = 2'd2;
  localparam logic [1:0] IC_VECBASE = 2'd3;

endpackage

// File: rtl/int_controller_if.sv
// CPU-side bundle of the interrupt controller: control-unit handshake plus
// the small register bus.
interface int_controller_if;
  logic        io_interrupt;
  logic        int_ack;
  logic        int_ret;
  logic [15:0] pc_in;
  logic [15:0] vec_out;
  logic [15:0] ret_out;
  logic [1:0]  reg_addr;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  modport master (
    output int_ack, int_ret, pc_in, reg_addr, reg_wr, reg_wdata,
    input  io_interrupt, vec_out, ret_out, reg_rdata
  );

  modport slave (
    input  int_ack, int_ret, pc_in, reg_addr, reg_wr, reg_wdata,
    output io_interrupt, vec_out, ret_out, reg_rdata
  );
endinterface

// File: rtl/int_controller_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins.
module prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the last hit, the lowest index, is kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Prioritising interrupt controller: latches request edges as pending,
// raises io_interrupt, and tracks one in-service source (no nesting).
module int_controller
  import cpu_defs::*;
#(
  parameter int          NUM_SRC  = 4,
  parameter logic [15:0] VEC_BASE = 16'h0010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  int_controller_if.slave    bus
);

  // state      | meaning
  // IC_IDLE    | nothing requested to the CPU
  // IC_REQ     | io_interrupt high, waiting for int_ack
  // IC_SERVICE | handler running, waiting for int_ret

  ic_state_e          state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] irq_d;
  logic [NUM_SRC-1:0] req, rise, clr_mask;
  logic [15:0]        vecbase_q;
  logic [15:0]        vec_q, ret_q;
  logic [2:0]         in_svc_id_q;
  logic [2:0]         sel;
  logic               req_valid;
  logic               take;
  logic               io_int_q;
  logic               wr_enable, wr_pending, wr_vecbase;

  assign rise = irq_src & ~irq_d;
  assign req  = pending_q & enable_q;

  prio_enc #(.N(NUM_SRC)) u_prio (
    .req   (req),
    .valid (req_valid),
    .idx   (sel)
  );

  assign wr_enable  = bus.reg_wr && (bus.reg_addr == IC_ENABLE);
  assign wr_pending = bus.reg_wr && (bus.reg_addr == IC_PENDING);
  assign wr_vecbase = bus.reg_wr && (bus.reg_addr == IC_VECBASE);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (req_valid) state_d = IC_REQ;
      end
      IC_REQ: begin
        if (bus.int_ack && req_valid) begin
          take    = 1'b1;
          state_d = IC_SERVICE;
        end else if (!req_valid) begin
          state_d = IC_IDLE;
        end
      end
      IC_SERVICE: begin
        if (bus.int_ret) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // New edges are OR-ed in last so they beat both W1C and the ack clear.
  always_comb begin
    clr_mask = '0;
    if (wr_pending) clr_mask = clr_mask | bus.reg_wdata[NUM_SRC-1:0];
    if (take)       clr_mask = clr_mask | (NUM_SRC'(1) << sel);
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IC_IDLE;
      pending_q   <= '0;
      enable_q    <= '0;
      irq_d       <= '0;
      vecbase_q   <= VEC_BASE;
      vec_q       <= '0;
      ret_q       <= '0;
      in_svc_id_q <= '0;
      io_int_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_d     <= irq_src;
      io_int_q  <= (state_d == IC_REQ);
      if (wr_enable)  enable_q  <= bus.reg_wdata[NUM_SRC-1:0];
      if (wr_vecbase) vecbase_q <= bus.reg_wdata;
      if (take) begin
        ret_q       <= bus.pc_in;
        vec_q       <= vecbase_q + {12'h000, sel, 1'b0};
        in_svc_id_q <= sel;
      end
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      IC_ENABLE:  bus.reg_rdata = {{(16-NUM_SRC){1'b0}}, enable_q};
      IC_PENDING: bus.reg_rdata = {{(16-NUM_SRC){1'b0}}, pending_q};
      IC_STATUS:  bus.reg_rdata = {(state_q == IC_SERVICE), 12'h000, in_svc_id_q};
      IC_VECBASE: bus.reg_rdata = vecbase_q;
      default:    bus.reg_rdata = '0;
    endcase
  end

  assign bus.io_interrupt = io_int_q;
  assign bus.vec_out      = vec_q;
  assign bus.ret_out      = ret_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: drives and samples on the falling edge.
module tb_int_controller;
  import cpu_defs::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_src;
  logic [15:0] rd;
  int n_checks;
  int n_fail;

  int_controller_if bus_if();

  int_controller #(.NUM_SRC(4), .VEC_BASE(16'h0010)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    bus_if.reg_addr  = a;
    bus_if.reg_wdata = d;
    bus_if.reg_wr    = 1'b1;
    cyc();
    bus_if.reg_wr    = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
    bus_if.reg_addr = a;
    #1;
    d = bus_if.reg_rdata;
  endtask

  task automatic ack(input logic [15:0] pc);
    bus_if.int_ack = 1'b1;
    bus_if.pc_in   = pc;
    cyc();
    bus_if.int_ack = 1'b0;
  endtask

  task automatic ret();
    bus_if.int_ret = 1'b1;
    cyc();
    bus_if.int_ret = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    irq_src  = '0;
    bus_if.int_ack   = 1'b0;
    bus_if.int_ret   = 1'b0;
    bus_if.pc_in     = '0;
    bus_if.reg_addr  = '0;
    bus_if.reg_wr    = 1'b0;
    bus_if.reg_wdata = '0;
    cyc(); cyc();

    check_eq("rst_io", 16'(bus_if.io_interrupt), 16'h0);
    check_eq("rst_vec", bus_if.vec_out, 16'h0000);
    reg_read(IC_VECBASE, rd); check_eq("rst_vecbase", rd, 16'h0010);
    reg_read(IC_ENABLE, rd);  check_eq("rst_enable", rd, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // single source, latency and vector
    reg_write(IC_ENABLE, 16'h0004);
    irq_src = 4'b0100; cyc(); irq_src = '0;
    check_eq("single_io_n1", 16'(bus_if.io_interrupt), 16'h0);
    reg_read(IC_PENDING, rd); check_eq("single_pend", rd, 16'h0004);
    cyc();
    check_eq("single_io_n2", 16'(bus_if.io_interrupt), 16'h1);
    ack(16'h0123);
    check_eq("single_vec", bus_if.vec_out, 16'h0014);
    check_eq("single_ret", bus_if.ret_out, 16'h0123);
    check_eq("single_io_svc", 16'(bus_if.io_interrupt), 16'h0);
    reg_read(IC_STATUS, rd);  check_eq("single_status", rd, 16'h8002);
    reg_read(IC_PENDING, rd); check_eq("single_pend_clr", rd, 16'h0000);
    ret();
    reg_read(IC_STATUS, rd);  check_eq("single_status_ret", rd, 16'h0002);
    check_eq("single_ret_hold", bus_if.ret_out, 16'h0123);

    // two sources same cycle: lowest index first
    reg_write(IC_ENABLE, 16'h000F);
    irq_src = 4'b1010; cyc(); irq_src = '0; cyc();
    check_eq("prio_io", 16'(bus_if.io_interrupt), 16'h1);
    ack(16'h0200);
    check_eq("prio_vec1", bus_if.vec_out, 16'h0012);
    reg_read(IC_STATUS, rd); check_eq("prio_status1", rd, 16'h8001);
    ret();
    check_eq("prio_io_after_ret", 16'(bus_if.io_interrupt), 16'h0);
    cyc();
    check_eq("prio_io_again", 16'(bus_if.io_interrupt), 16'h1);
    ack(16'h0204);
    check_eq("prio_vec2", bus_if.vec_out, 16'h0016);
    reg_read(IC_STATUS, rd); check_eq("prio_status2", rd, 16'h8003);
    ret();

    // masked source stays pending until enabled
    reg_write(IC_ENABLE, 16'h0000);
    irq_src = 4'b0001; cyc(); irq_src = '0; cyc(); cyc();
    check_eq("mask_io", 16'(bus_if.io_interrupt), 16'h0);
    reg_read(IC_PENDING, rd); check_eq("mask_pend", rd, 16'h0001);
    reg_write(IC_ENABLE, 16'h0001);
    check_eq("mask_io_n1", 16'(bus_if.io_interrupt), 16'h0);
    cyc();
    check_eq("mask_io_n2", 16'(bus_if.io_interrupt), 16'h1);
    ack(16'h0300);
    check_eq("mask_vec", bus_if.vec_out, 16'h0010);
    ret();

    // W1C racing a new edge: the edge wins
    irq_src = 4'b0001;
    bus_if.reg_addr = IC_PENDING; bus_if.reg_wdata = 16'h0001; bus_if.reg_wr = 1'b1;
    cyc();
    bus_if.reg_wr = 1'b0; irq_src = '0;
    reg_read(IC_PENDING, rd); check_eq("race_pend", rd, 16'h0001);
    reg_write(IC_PENDING, 16'h0001);
    reg_read(IC_PENDING, rd); check_eq("w1c_pend", rd, 16'h0000);
    cyc();
    check_eq("req_drop_io", 16'(bus_if.io_interrupt), 16'h0);

    // no nesting; stray acks ignored
    irq_src = 4'b0001; cyc(); irq_src = '0; cyc();
    check_eq("nest_io", 16'(bus_if.io_interrupt), 16'h1);
    ack(16'h0400);
    irq_src = 4'b0001; cyc(); irq_src = '0; cyc(); cyc();
    check_eq("nest_io_svc", 16'(bus_if.io_interrupt), 16'h0);
    reg_read(IC_PENDING, rd); check_eq("nest_pend", rd, 16'h0001);
    ack(16'hDEAD);
    check_eq("nest_stray_ack", bus_if.ret_out, 16'h0400);
    ret();
    check_eq("nest_io_ret", 16'(bus_if.io_interrupt), 16'h0);
    cyc();
    check_eq("nest_io_raise", 16'(bus_if.io_interrupt), 16'h1);
    ack(16'h0500);
    check_eq("nest_ret2", bus_if.ret_out, 16'h0500);
    ret(); cyc();
    ack(16'hBEEF);
    check_eq("idle_ack_ret", bus_if.ret_out, 16'h0500);
    check_eq("idle_ack_io", 16'(bus_if.io_interrupt), 16'h0);
    reg_read(IC_STATUS, rd); check_eq("idle_ack_status", rd, 16'h0000);

    // vector wrap, ack uses old enable on same-cycle ENABLE write
    reg_write(IC_VECBASE, 16'hFFFE);
    reg_write(IC_ENABLE, 16'h0002);
    irq_src = 4'b0010; cyc(); irq_src = '0; cyc();
    check_eq("wrap_io", 16'(bus_if.io_interrupt), 16'h1);
    bus_if.reg_addr = IC_ENABLE; bus_if.reg_wdata = 16'h0000; bus_if.reg_wr = 1'b1;
    ack(16'h0600);
    bus_if.reg_wr = 1'b0;
    check_eq("wrap_vec", bus_if.vec_out, 16'h0000);
    check_eq("wrap_ret", bus_if.ret_out, 16'h0600);
    reg_read(IC_STATUS, rd); check_eq("wrap_status", rd, 16'h8001);
    reg_read(IC_ENABLE, rd); check_eq("wrap_enable", rd, 16'h0000);

    // async reset mid-SERVICE
    rst_n = 1'b0;
    #1;
    check_eq("rst2_io", 16'(bus_if.io_interrupt), 16'h0);
    check_eq("rst2_vec", bus_if.vec_out, 16'h0000);
    check_eq("rst2_ret", bus_if.ret_out, 16'h0000);
    reg_read(IC_STATUS, rd);  check_eq("rst2_status", rd, 16'h0000);
    reg_read(IC_VECBASE, rd); check_eq("rst2_vecbase", rd, 16'h0010);
    reg_read(IC_PENDING, rd); check_eq("rst2_pend", rd, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
